// File: rtl/sync_fifo.sv
// Purpose : single-clock register-array FIFO with full/empty status and error pulses.
// Latency : rd_data is valid one cycle after an accepted read; full/empty follow
//           one cycle after the accepted request.
// Backpressure : a write while full is dropped unless a read is accepted in the same cycle.
//                A read while empty is dropped. Each dropped request raises a
//                registered one-cycle error flag (overflow/underflow).
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous reset, ACTIVE HIGH (name kept for compatibility)
//   wr_en      write request, wr_data written when accepted
//   rd_en      read request, rd_data updated when accepted
//   rd_data    registered read data, holds value between reads
//   full       DEPTH entries stored
//   empty      no entries stored
//   underflow  pulse the cycle after a rejected read
//   overflow   pulse the cycle after a rejected write
module sync_fifo #(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  underflow,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // One extra MSB on each pointer distinguishes full from empty when the
  // index bits coincide.
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;

  logic rd_acc;
  logic wr_acc;

  // Status decoded purely from registered pointers.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                 (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

  assign rd_acc = rd_en && !empty;
  // A write into a full FIFO is allowed when a read frees a slot on the same edge.
  assign wr_acc = wr_en && (!full || rd_acc);

  // Storage has no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_data   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        rd_ptr  <= rd_ptr + PTR_ONE;
      end
      overflow  <= wr_en && !wr_acc;
      underflow <= rd_en && empty;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       full;
  logic       empty;
  logic       underflow;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] model_q [$];

  sync_fifo #(.DEPTH(32), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .full      (full),
    .empty     (empty),
    .underflow (underflow),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({empty, full, rd_data, overflow, underflow} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset: empty=%b full=%b rd_data=%h ovf=%b unf=%b, want 1 0 00 0 0",
               empty, full, rd_data, overflow, underflow);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_data = 8'(i);
      step();
      n_cmp++;
      if ({empty, full, overflow} !== {1'b0, (i == 31), 1'b0}) begin
        n_bad++;
        $display("FAIL fill[%0d]: empty=%b full=%b ovf=%b, want 0 %b 0",
                 i, empty, full, overflow, (i == 31));
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_overflow();
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'hAA;
    step();
    n_cmp++;
    if ({overflow, full} !== 2'b11) begin
      n_bad++;
      $display("FAIL overflow_pulse: ovf=%b full=%b, want 1 1", overflow, full);
    end
    @(negedge clk);
    wr_en = 1'b0;
    step();
    n_cmp++;
    if ({overflow, full} !== 2'b01) begin
      n_bad++;
      $display("FAIL overflow_clear: ovf=%b full=%b, want 0 1", overflow, full);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rd_en = 1'b1;
      step();
      n_cmp++;
      if (rd_data !== 8'(i) || full !== 1'b0) begin
        n_bad++;
        $display("FAIL drain[%0d]: rd_data=%h full=%b, want %h 0", i, rd_data, full, 8'(i));
      end
    end
    n_cmp++;
    if (empty !== 1'b1) begin
      n_bad++;
      $display("FAIL drain_empty: empty=%b, want 1", empty);
    end
    @(negedge clk);
    rd_en = 1'b0;
    step();
    n_cmp++;
    if (rd_data !== 8'h1F || underflow !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_hold: rd_data=%h unf=%b, want 1f 0", rd_data, underflow);
    end
  endtask

  task automatic test_underflow();
    // Sustained illegal reads keep the flag high each cycle; rd_data untouched.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rd_en = 1'b1;
      step();
      n_cmp++;
      if (underflow !== 1'b1 || rd_data !== 8'h1F || empty !== 1'b1) begin
        n_bad++;
        $display("FAIL underflow[%0d]: unf=%b rd_data=%h empty=%b, want 1 1f 1",
                 i, underflow, rd_data, empty);
      end
    end
    @(negedge clk);
    rd_en = 1'b0;
    step();
    n_cmp++;
    if (underflow !== 1'b0) begin
      n_bad++;
      $display("FAIL underflow_clear: unf=%b, want 0", underflow);
    end
    // Write and read together while empty: write lands, read is rejected.
    @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h77;
    step();
    n_cmp++;
    if ({underflow, empty, overflow} !== 3'b100 || rd_data !== 8'h1F) begin
      n_bad++;
      $display("FAIL wr_rd_empty: unf=%b empty=%b ovf=%b rd_data=%h, want 1 0 0 1f",
               underflow, empty, overflow, rd_data);
    end
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    n_cmp++;
    if (rd_data !== 8'h77 || empty !== 1'b1 || underflow !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_rd_empty_read: rd_data=%h empty=%b unf=%b, want 77 1 0",
               rd_data, empty, underflow);
    end
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic test_wrap_concurrency();
    logic [7:0] exp;
    model_q.delete();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_data = 8'(8'h40 + i);
      model_q.push_back(8'(8'h40 + i));
      step();
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(8'h80 + i);
      exp = model_q.pop_front();
      model_q.push_back(8'(8'h80 + i));
      step();
      n_cmp++;
      if (rd_data !== exp || {full, empty, overflow, underflow} !== 4'b0000) begin
        n_bad++;
        $display("FAIL wrap[%0d]: rd_data=%h flags(f,e,o,u)=%b%b%b%b, want %h 0000",
                 i, rd_data, full, empty, overflow, underflow, exp);
      end
    end
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_mid_reset();
    // Occupancy is 16 here; reset mid-cycle must clear it without a clock edge.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({empty, full, rd_data} !== {1'b1, 1'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL mid_reset: empty=%b full=%b rd_data=%h, want 1 0 00", empty, full, rd_data);
    end
    // Requests during reset are ignored.
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h55;
    step();
    n_cmp++;
    if ({empty, overflow, underflow} !== 3'b100) begin
      n_bad++;
      $display("FAIL reset_ignore: empty=%b ovf=%b unf=%b, want 1 0 0", empty, overflow, underflow);
    end
    @(negedge clk);
    rst_n = 1'b0; wr_en = 1'b1; rd_en = 1'b0; wr_data = 8'h3C;
    step();
    n_cmp++;
    if (empty !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_write: empty=%b, want 0", empty);
    end
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    n_cmp++;
    if (rd_data !== 8'h3C || empty !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset_read: rd_data=%h empty=%b, want 3c 1", rd_data, empty);
    end
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_wrap_concurrency();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
